// File: rtl/slave_fifo_pkg.sv
// Shared constants and helpers for the parametrised MCDF slave FIFO.
package slave_fifo_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_PTR_W  = 3;

  localparam bit FIFO_MODE_STD  = 1'b0;
  localparam bit FIFO_MODE_FWFT = 1'b1;

  function automatic int fifo_depth(input int ptr_w);
    return 1 << ptr_w;
  endfunction

endpackage

// File: rtl/slave_fifo_ram.sv
// DEPTH x DATA_W storage: synchronous write, asynchronous read, entries reset to zero.
module slave_fifo_ram
  import slave_fifo_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int PTR_W  = DEFAULT_PTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = fifo_depth(PTR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/slave_fifo_param.sv
// Parametrised slave FIFO: pointers, occupancy, watermarks, flush and the
// standard / first-word-fall-through read path around slave_fifo_ram.
module slave_fifo_param
  import slave_fifo_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int PTR_W    = DEFAULT_PTR_W,
  parameter bit FWFT     = FIFO_MODE_STD,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              uplink_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              uplink_ready,
  input  logic              downlink_valid,
  output logic              downlink_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [PTR_W:0]    fifo_count,
  output logic [PTR_W:0]    fifo_slack,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam int               DEPTH     = fifo_depth(PTR_W);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   AF_CNT    = (PTR_W+1)'(AF_LEVEL);
  localparam logic [PTR_W:0]   AE_CNT    = (PTR_W+1)'(AE_LEVEL);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] rd_data;

  // Handshake: a transfer happens on an edge where valid && ready. Ready is a
  // function of registered occupancy and flush only, never of the valids, so
  // a full FIFO refuses a same-cycle push and an empty one refuses a pop.
  assign uplink_ready   = !flush && (count != DEPTH_CNT);
  assign downlink_ready = !flush && (count != '0);
  assign push           = uplink_valid && uplink_ready;
  assign pop            = downlink_valid && downlink_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  slave_fifo_ram #(
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  assign fifo_count   = count;
  assign fifo_slack   = DEPTH_CNT - count;
  assign almost_full  = (count >= AF_CNT);
  assign almost_empty = (count <= AE_CNT);

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is shown directly; an empty FIFO presents zero.
      assign data_out = (count != '0) ? rd_data : '0;
    end else begin : g_std
      logic [DATA_W-1:0] data_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_q <= '0;
        end else if (flush) begin
          data_q <= '0;
        end else if (pop) begin
          data_q <= rd_data;
        end
      end

      assign data_out = data_q;
    end
  endgenerate

endmodule

// File: tb/tb_slave_fifo_param.sv
// Bench for slave_fifo_param: one standard-mode and one FWFT instance share stimulus;
// a queue-based reference model feeds a scoreboard checked by a negedge monitor.
module tb_slave_fifo_param;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        uv;
  logic        dv;
  logic [31:0] data_in;

  logic        s_ur, s_dr, s_af, s_ae;
  logic [31:0] s_do;
  logic [3:0]  s_cnt, s_slack;
  logic        f_ur, f_dr, f_af, f_ae;
  logic [31:0] f_do;
  logic [3:0]  f_cnt, f_slack;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  slave_fifo_param #(.FWFT(1'b0)) dut_std (
    .clk(clk), .rst(rst), .flush(flush),
    .uplink_valid(uv), .data_in(data_in), .uplink_ready(s_ur),
    .downlink_valid(dv), .downlink_ready(s_dr), .data_out(s_do),
    .fifo_count(s_cnt), .fifo_slack(s_slack),
    .almost_full(s_af), .almost_empty(s_ae)
  );

  slave_fifo_param #(.FWFT(1'b1)) dut_fwft (
    .clk(clk), .rst(rst), .flush(flush),
    .uplink_valid(uv), .data_in(data_in), .uplink_ready(f_ur),
    .downlink_valid(dv), .downlink_ready(f_dr), .data_out(f_do),
    .fifo_count(f_cnt), .fifo_slack(f_slack),
    .almost_full(f_af), .almost_empty(f_ae)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] model_q[$];
  logic [31:0] exp_q[$];
  bit          pop_flag;
  bit          clear_ev;
  int          pre_n;

  always @(posedge clk or posedge rst) begin
    pop_flag = 1'b0;
    clear_ev = 1'b0;
    if (rst) begin
      model_q.delete();
      clear_ev = 1'b1;
    end else if (flush) begin
      model_q.delete();
      clear_ev = 1'b1;
    end else begin
      pre_n = model_q.size();
      if (dv && pre_n != 0) begin
        exp_q.push_back(model_q.pop_front());
        pop_flag = 1'b1;
      end
      if (uv && pre_n != DEPTH) model_q.push_back(data_in);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [31:0] exp_std = '0;
  logic [31:0] exp_fw;
  int          n;

  always @(negedge clk) begin
    if (clear_ev) begin
      exp_q.delete();
      exp_std = '0;
    end else if (pop_flag) begin
      if (exp_q.size() == 0) check("std_scoreboard_empty", 32'd1, 32'd0);
      else exp_std = exp_q.pop_front();
    end
    n = model_q.size();
    exp_fw = (n != 0) ? model_q[0] : 32'd0;

    check("std_count",          s_cnt,   n);
    check("std_slack",          s_slack, DEPTH - n);
    check("std_almost_full",    s_af,    n >= 6);
    check("std_almost_empty",   s_ae,    n <= 2);
    check("std_uplink_ready",   s_ur,    !flush && n != DEPTH);
    check("std_downlink_ready", s_dr,    !flush && n != 0);
    check("std_data_out",       s_do,    exp_std);

    check("fwft_count",          f_cnt,   n);
    check("fwft_slack",          f_slack, DEPTH - n);
    check("fwft_almost_full",    f_af,    n >= 6);
    check("fwft_almost_empty",   f_ae,    n <= 2);
    check("fwft_uplink_ready",   f_ur,    !flush && n != DEPTH);
    check("fwft_downlink_ready", f_dr,    !flush && n != 0);
    check("fwft_data_out",       f_do,    exp_fw);
  end

  // ---------------- driver ----------------
  task automatic drive(input logic u, input logic [31:0] d, input logic v, input logic f);
    uv      = u;
    data_in = d;
    dv      = v;
    flush   = f;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; uv = 1'b0; dv = 1'b0; data_in = '0;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Fill 1..8, one extra offer while full, then drain 8.
    for (int i = 1; i <= 8; i++) drive(1'b1, 32'(i), 1'b0, 1'b0);
    drive(1'b1, 32'h99, 1'b0, 1'b0);
    // Full with simultaneous push/pop: 0xAA refused, accepted on the next edge.
    drive(1'b1, 32'hAA, 1'b1, 1'b0);
    drive(1'b1, 32'hAA, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 32'd0, 1'b1, 1'b0);
    idle(1);

    // Empty with simultaneous push/pop: push only.
    drive(1'b1, 32'h55, 1'b1, 1'b0);
    idle(1);

    // Bring count to 3, then stream 20 words with continuous push/pop.
    drive(1'b1, 32'h101, 1'b0, 1'b0);
    drive(1'b1, 32'h102, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, $urandom, 1'b1, 1'b0);
    idle(1);

    // Count to 5, then flush with a push of 0x77 offered.
    drive(1'b1, 32'h201, 1'b0, 1'b0);
    drive(1'b1, 32'h202, 1'b0, 1'b0);
    drive(1'b1, 32'h77, 1'b0, 1'b1);
    idle(1);
    drive(1'b1, 32'h301, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 1'b1, 1'b0);
    idle(1);

    // Randomised traffic: fill-biased half, then drain-biased half, rare flushes.
    for (int i = 0; i < 400; i++) begin
      if (i < 200)
        drive($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 40,
              $urandom_range(0, 49) == 0);
      else
        drive($urandom_range(0, 99) < 40, $urandom, $urandom_range(0, 99) < 70,
              $urandom_range(0, 49) == 0);
    end
    idle(1);
    drive(1'b0, 32'd0, 1'b0, 1'b1);

    // Asynchronous reset mid-cycle at count 4.
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_std_uplink_ready",    s_ur,    32'd1);
    check("arst_std_downlink_ready",  s_dr,    32'd0);
    check("arst_std_slack",           s_slack, 32'd8);
    check("arst_std_count",           s_cnt,   32'd0);
    check("arst_std_almost_empty",    s_ae,    32'd1);
    check("arst_std_almost_full",     s_af,    32'd0);
    check("arst_std_data_out",        s_do,    32'd0);
    check("arst_fwft_uplink_ready",   f_ur,    32'd1);
    check("arst_fwft_slack",          f_slack, 32'd8);
    check("arst_fwft_data_out",       f_do,    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Post-reset traffic and a final drain.
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 32'd0, 1'b1, 1'b0);
    idle(2);
    check("scoreboard_left", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
